regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the CPU datapath.
- Generalises the fixed 32x32, three-read-port file to configurable width, depth and read-port count.
- Adds a post-reset init sequencer, write-to-read bypass, and an optional staged-commit mode in which writes stay invisible until a commit strobe.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- DW, 32, data width in bits
- AW, 5, address width; depth = 2**AW
- NRD, 3, number of read ports (1..8)
- ZERO_R0, 1, 1 = entry 0 always reads 0 and ignores writes
- INIT_IDX, 1, 1 = init writes entry i with value i (zero-extended to DW); 0 = init writes 0
- STAGED, 0, 0 = writes visible next cycle; 1 = writes staged until commit
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports (visible path only)

Ports:
- clk, in, 1, single clock, rising edge
- Rst_n, in, 1, asynchronous active-low reset
- raddr, in, NRD*AW, read addresses; port k = bits [k*AW +: AW]
- rdata, out, NRD*DW, read data; port k = bits [k*DW +: DW]
- we, in, 1, write enable
- waddr, in, AW, write address
- wdata, in, DW, write data
- commit, in, 1, STAGED=1 only: copy the pending array to the visible array
- busy, out, 1, init sequencer running; writes and commits are ignored while high
- wr_drop, out, 1, one-cycle pulse: a write or commit was ignored because busy was high

Behaviour:
- Storage: visible array V[2**AW]. When STAGED=1, also a pending array P[2**AW]. Arrays are not individually reset.

Init FSM (states IDLE, INIT, READY):
- Rst_n low (async): state=INIT, idx=0, busy=1, wr_drop=0.
- INIT: each cycle writes init value to V[idx] (and to P[idx] if STAGED), then idx++.
- When idx reaches 2**AW-1, that entry is written and the FSM moves to READY; busy falls on the same edge.
- Init therefore takes exactly 2**AW cycles after Rst_n deassertion.
- READY: normal operation. Stays READY until the next reset.
- IDLE is only the encoding-default state; it transitions to INIT on the first clock.
- Reset asserted mid-INIT or mid-operation restarts INIT from idx=0. Pending staged data is lost.

Read (combinational):
- rdata[k] = V[raddr[k]].
- ZERO_R0=1 and raddr[k]==0 -> 0.
- While busy, rdata = 0 on all ports.
- BYPASS=1, STAGED=0: if we && waddr==raddr[k] (and not the R0 case) -> rdata[k]=wdata in the same cycle.
- No bypass from P in STAGED mode.

Write (READY only):
- STAGED=0: on the rising edge with we, V[waddr] <= wdata.
- STAGED=1: on the rising edge with we, P[waddr] <= wdata. V is unchanged.
- On the rising edge with commit, V <= P for all entries; V is updated one cycle after commit.
- we and commit in the same cycle: the write lands in P and is included in that commit (V[waddr]=wdata after the edge).
- ZERO_R0=1 and waddr==0: write discarded, no wr_drop.
- Writes to the same address on consecutive cycles: last write wins.
- busy=1 and (we or commit): ignored; wr_drop=1 on the next cycle, else wr_drop=0.

Widths:
- Init value = idx zero-extended/truncated to DW.
- Out-of-range addresses cannot occur (depth = 2**AW).

Test Plan:
1. Default params, release Rst_n, count cycles -> busy high for exactly 32 cycles. Afterwards raddr={5,3,0} -> rdata ports 0,1,2 = 5, 3, 0.
2. READY, we=1, waddr=7, wdata=0xDEADBEEF, raddr port0=7 in the same cycle -> rdata0=0xDEADBEEF combinationally (bypass). Next cycle with we=0 -> still 0xDEADBEEF.
3. Write waddr=0, wdata=0x1234 -> reading reg 0 returns 0; wr_drop stays 0.
4. STAGED=1: write reg 9=0xA5A5A5A5 -> reg 9 still reads 9. Pulse commit -> next cycle reads 0xA5A5A5A5. Same-cycle we (reg 10=0x55) + commit -> reg 10 reads 0x55 after that edge.
5. Assert Rst_n at cycle 10 of INIT, release -> idx restarts and busy lasts a full 32 cycles. we during busy -> wr_drop pulses for 1 cycle; the target reg keeps its init value.
6. DW=16, AW=3, NRD=4, INIT_IDX=0 -> busy for 8 cycles; all four ports read 0. Write reg 6=0xBEEF -> all ports with raddr=6 read 0xBEEF.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp - parametrised multi-read-port register file for the CPU datapath.
//
// After reset an init sequencer fills every entry (value = index, or zero) and
// holds busy high until done. In direct mode (STAGED=0) writes become visible
// on the next cycle. A same-cycle write can also be forwarded to matching read
// ports (BYPASS). In staged mode (STAGED=1) writes land in a pending array. A
// commit strobe copies the pending array into the visible array.
//
// Ports:
//   clk      in   1        rising-edge clock
//   Rst_n    in   1        asynchronous active-low reset
//   raddr    in   NRD*AW   read addresses, port k = [k*AW +: AW]
//   rdata    out  NRD*DW   read data,      port k = [k*DW +: DW]
//   we       in   1        write enable
//   waddr    in   AW       write address
//   wdata    in   DW       write data
//   commit   in   1        staged mode: publish pending array to visible array
//   busy     out  1        init sequencer running; writes/commits ignored
//   wr_drop  out  1        one-cycle pulse after an ignored write or commit
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 3,
    parameter int ZERO_R0  = 1,
    parameter int INIT_IDX = 1,
    parameter int STAGED   = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              commit,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_drop_q, wr_drop_d;
    logic          init_we;
    logic [DW-1:0] init_val;
    logic          wr_ok;

    logic [DW-1:0] mem_v_q [DEPTH];

    // Control state only; the storage arrays are deliberately not reset.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= INIT;
            idx_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        init_we = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = INIT;
                idx_d   = '0;
            end
            INIT: begin
                init_we = 1'b1;
                // The last entry is written on the same edge that leaves INIT.
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
    end

    assign busy      = (state_q != READY);
    assign wr_drop   = wr_drop_q;
    assign wr_drop_d = busy && (we || commit);

    assign init_val = (INIT_IDX != 0) ? DW'(idx_q) : '0;

    // Writes to entry 0 are silently discarded when it is hardwired to zero.
    assign wr_ok = (state_q == READY) && we && !((ZERO_R0 != 0) && (waddr == '0));

    // Combinational read with optional same-cycle forwarding of the write port.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!busy && !((ZERO_R0 != 0) && (raddr[k*AW +: AW] == '0))) begin
                if ((BYPASS != 0) && (STAGED == 0) && wr_ok && (waddr == raddr[k*AW +: AW])) begin
                    rdata[k*DW +: DW] = wdata;
                end else begin
                    rdata[k*DW +: DW] = mem_v_q[raddr[k*AW +: AW]];
                end
            end
        end
    end

    generate
        if (STAGED == 0) begin : g_direct
            always_ff @(posedge clk) begin
                if (init_we) begin
                    mem_v_q[idx_q] <= init_val;
                end else if (wr_ok) begin
                    mem_v_q[waddr] <= wdata;
                end
            end
        end else begin : g_staged
            logic [DW-1:0] mem_p_q [DEPTH];
            logic          commit_ok;

            assign commit_ok = (state_q == READY) && commit;

            always_ff @(posedge clk) begin
                if (init_we) begin
                    mem_p_q[idx_q] <= init_val;
                end else if (wr_ok) begin
                    mem_p_q[waddr] <= wdata;
                end
            end

            // A write in the commit cycle is folded into the copy so it is
            // published on the same edge.
            always_ff @(posedge clk) begin
                if (init_we) begin
                    mem_v_q[idx_q] <= init_val;
                end else if (commit_ok) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_v_q[i] <= (wr_ok && (waddr == AW'(i))) ? wdata : mem_p_q[i];
                    end
                end
            end
        end
    endgenerate

endmodule
